// File: rtl/transmit_cg_rd.sv
// 1000BASE-X PCS transmit code-group generator: ordered-set request + TXD in,
// one 8b/10b code-group per GTX_CLK out, with running-disparity tracking.
module transmit_cg_rd #(
  parameter bit CONFIG_EN    = 1'b1,
  parameter bit IDLE_CORRECT = 1'b1,
  parameter bit INIT_RD      = 1'b0
) (
  input  logic        GTX_CLK,
  input  logic        mr_main_reset,
  input  logic [6:0]  tx_o_set,
  input  logic [7:0]  TXD,
  input  logic [15:0] tx_config_reg,
  output logic [9:0]  tx_code_group,
  output logic        tx_even,
  output logic        TX_OSET_indicate,
  output logic        tx_disparity
);

  typedef enum logic [2:0] {
    GEN     = 3'd0,
    IDLE_D  = 3'd1,
    CONF_D  = 3'd2,
    CONF_LO = 3'd3,
    CONF_HI = 3'd4
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;

  // Returns {rd_after, abcdei, fghj}. Tables hold the RD- column; the RD+ column
  // is the complement for every unbalanced sub-block plus D.x.3/D.7 and all K 4b codes.
  function automatic logic [10:0] encode_8b10b(input logic [7:0] d, input logic k,
                                               input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd_mid;
    logic       rd_out;
    logic       alt7;
    x  = d[4:0];
    y  = d[7:5];
    c6 = 6'b000000;
    case (x)
      5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;
      5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
      5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
      5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
      5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;
      5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
      5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;
      5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
      5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
      5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
      5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;
      5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
      5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;
      5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
      5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
      5'd30: c6 = 6'b011110;  5'd31: c6 = 6'b101011;
      default: c6 = 6'b000000;
    endcase
    if (k && x == 5'd28) c6 = 6'b001111;
    if (rd && ($countones(c6) != 3 || c6 == 6'b111000)) c6 = ~c6;
    rd_mid = ($countones(c6) == 3) ? rd : ($countones(c6) > 3);

    alt7 = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
           ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    c4 = 4'b0000;
    if (k) begin
      case (y)
        3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b0110;
        3'd2: c4 = 4'b1010;  3'd3: c4 = 4'b1100;
        3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b0101;
        3'd6: c4 = 4'b1001;  3'd7: c4 = 4'b0111;
        default: c4 = 4'b0000;
      endcase
    end else begin
      case (y)
        3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b1001;
        3'd2: c4 = 4'b0101;  3'd3: c4 = 4'b1100;
        3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b1010;
        3'd6: c4 = 4'b0110;  3'd7: c4 = alt7 ? 4'b0111 : 4'b1110;
        default: c4 = 4'b0000;
      endcase
    end
    if (rd_mid && (k || $countones(c4) != 2 || c4 == 4'b1100)) c4 = ~c4;
    rd_out = ($countones(c4) == 2) ? rd_mid : ($countones(c4) > 2);
    return {rd_out, c6, c4};
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  code_q, code_d;
  logic        even_q, even_d;
  logic        ind_q, ind_d;
  logic        rd_q, rd_d;
  logic        c2_q, c2_d;
  logic [15:0] cfg_q, cfg_d;
  logic [7:0]  sym;
  logic        sym_k;
  logic [10:0] enc;

  always_comb begin
    state_d = GEN;
    sym     = K30_7;
    sym_k   = 1'b1;
    even_d  = ~even_q;
    ind_d   = 1'b1;
    c2_d    = c2_q;
    cfg_d   = cfg_q;
    case (state_q)
      GEN: begin
        case (tx_o_set)
          7'b0000001: begin
            sym = K28_5; even_d = 1'b1; ind_d = 1'b0; state_d = IDLE_D;
          end
          7'b1000000: begin
            sym = K28_5; even_d = 1'b1; ind_d = 1'b0;
            state_d = CONFIG_EN ? CONF_D : IDLE_D;
          end
          7'b0000010: sym = K23_7;
          7'b0000100: sym = K27_7;
          7'b0001000: sym = K29_7;
          7'b0100000: begin
            sym = TXD; sym_k = 1'b0;
          end
          default: sym = K30_7;
        endcase
      end
      IDLE_D: begin
        sym    = (!rd_q && IDLE_CORRECT) ? D5_6 : D16_2;
        sym_k  = 1'b0;
        even_d = 1'b0;
      end
      CONF_D: begin
        sym     = c2_q ? D2_2 : D21_5;
        sym_k   = 1'b0;
        c2_d    = ~c2_q;
        cfg_d   = tx_config_reg;
        even_d  = 1'b0;
        ind_d   = 1'b0;
        state_d = CONF_LO;
      end
      CONF_LO: begin
        sym     = cfg_q[7:0];
        sym_k   = 1'b0;
        even_d  = 1'b1;
        ind_d   = 1'b0;
        state_d = CONF_HI;
      end
      CONF_HI: begin
        sym    = cfg_q[15:8];
        sym_k  = 1'b0;
        even_d = 1'b0;
      end
      default: sym = K30_7;
    endcase
    enc    = encode_8b10b(sym, sym_k, rd_q);
    code_d = enc[9:0];
    rd_d   = enc[10];
  end

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q <= GEN;
      code_q  <= 10'd0;
      even_q  <= 1'b0;
      ind_q   <= 1'b0;
      rd_q    <= INIT_RD;
      c2_q    <= 1'b0;
      cfg_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      even_q  <= even_d;
      ind_q   <= ind_d;
      rd_q    <= rd_d;
      c2_q    <= c2_d;
      cfg_q   <= cfg_d;
    end
  end

  assign tx_code_group    = code_q;
  assign tx_even          = even_q;
  assign TX_OSET_indicate = ind_q;
  assign tx_disparity     = rd_q;

endmodule
